fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of mainDec.

---
 rtl/fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, DEPTH-entry instruction FIFO, redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module fetch_unit #(
    parameter int unsigned      PC_W     = 32,
    parameter int unsigned      INSTR_W  = 32,
    parameter int unsigned      DEPTH    = 2,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [4:0]         op,
    output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t state, state_next;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    tag_pc;
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [PC_W-1:0]    fifo_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               empty;
    logic               full;
    logic               issue;
    logic               push;
    logic               pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // A response arriving in a redirect cycle completes the transaction but is never pushed.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (!redirect && !full && !reset) begin
                    issue      = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    push       = !redirect;
                    state_next = ST_RUN;
                end else if (redirect) begin
                    state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
        pop       = !empty && instr_ready && !redirect;
        imem_req  = issue;
        imem_addr = pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            tag_pc <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (redirect) begin
                pc <= redirect_pc;
            end else if (issue) begin
                pc     <= pc + PC_W'(4);
                tag_pc <= pc;
            end

            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= tag_pc;
        end
    end

    always_comb begin
        instr_valid = !empty;
        instr       = empty ? '0 : fifo_instr[rd_ptr];
        instr_pc    = empty ? '0 : fifo_pc[rd_ptr];
        op          = instr[INSTR_W-1 -: 5];
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full));
        end
    end
`endif

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (instr_valid && !instr_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (redirect && (!empty || (state != ST_RUN)) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a cycle-stepped imem model of programmable latency.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [4:0]  op;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // imem model state
    int          lat = 1;
    bit          pend = 1'b0;
    int          left = 0;
    logic [31:0] paddr = '0;
    bit          bad_data = 1'b0;

    // values observed in the most recent stepped cycle
    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_instr;
    logic [4:0]  obs_op;
    logic [31:0] obs_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_W(32),
        .INSTR_W(32),
        .DEPTH(2),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .op(op),
        .instr_pc(instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {~a[6:2], 3'b101, a[23:0]};
    endfunction

    // One clock cycle: drive memory response, settle, sample, advance to posedge+1.
    task step();
        if (pend && left == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = bad_data ? 32'hDEADBEEF : word_of(paddr);
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (pend) left--;
        end
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_instr = instr;
        obs_op    = op;
        obs_pc    = instr_pc;
        if (imem_req) begin
            checks++;
            if (pend !== 1'b0) begin
                errors++;
                $display("FAIL outstanding: got second request at %h expected none while pending", imem_addr);
            end
            pend  = 1'b1;
            left  = lat - 1;
            paddr = imem_addr;
        end
        @(posedge clk);
        #1;
    endtask

    task do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend        = 1'b0;
        bad_data    = 1'b0;
        lat         = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task test_reset();
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
        checks++; if (op !== 5'h0) begin errors++; $display("FAIL reset_op: got %h expected 0", op); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", instr_pc); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        do_reset();
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] w;
        bit          prev_req;
        int          first_valid;
        do_reset();
        exp_addr    = 0;
        exp_pc      = 0;
        prev_req    = 1'b0;
        first_valid = -1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (obs_req) begin
                checks++; if (obs_addr !== exp_addr) begin errors++; $display("FAIL stream_addr: got %h expected %h", obs_addr, exp_addr); end
                checks++; if (prev_req) begin errors++; $display("FAIL stream_cadence: got back-to-back request at cycle %0d expected gap", i); end
                exp_addr += 4;
            end
            if (obs_valid) begin
                if (first_valid < 0) first_valid = i;
                w = word_of(exp_pc);
                checks++; if (obs_instr !== w) begin errors++; $display("FAIL stream_instr: got %h expected %h", obs_instr, w); end
                checks++; if (obs_op !== w[31:27]) begin errors++; $display("FAIL stream_op: got %h expected %h", obs_op, w[31:27]); end
                checks++; if (obs_pc !== exp_pc) begin errors++; $display("FAIL stream_pc: got %h expected %h", obs_pc, exp_pc); end
                exp_pc += 4;
            end
            prev_req = obs_req;
        end
        checks++; if (first_valid !== 2) begin errors++; $display("FAIL stream_latency: got first valid at cycle %0d expected 2", first_valid); end
        checks++; if (exp_pc !== 32'd24) begin errors++; $display("FAIL stream_count: got %0d instrs expected 6", exp_pc / 4); end
    endtask

    task automatic test_stall();
        int          nreq;
        logic [31:0] w;
        do_reset();
        instr_ready = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_req) nreq++;
            if (i >= 4) begin
                checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL stall_req: got 1 at cycle %0d expected 0", i); end
            end
        end
        checks++; if (nreq !== 2) begin errors++; $display("FAIL stall_nreq: got %0d expected 2", nreq); end
        checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin errors++; $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=0", obs_valid, obs_pc); end
        instr_ready = 1'b1;
        step();
        w = word_of(32'h0);
        checks++; if (obs_valid !== 1'b1 || obs_instr !== w) begin errors++; $display("FAIL stall_pop0: got v=%b %h expected %h", obs_valid, obs_instr, w); end
        checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL stall_full_req: got %b expected 0", obs_req); end
        step();
        checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h4) begin errors++; $display("FAIL stall_pop1: got v=%b pc=%h expected pc=4", obs_valid, obs_pc); end
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h8) begin errors++; $display("FAIL stall_resume: got req=%b addr=%h expected addr 8", obs_req, obs_addr); end
        step();
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", obs_valid); end
        step();
        checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h8) begin errors++; $display("FAIL stall_next: got v=%b pc=%h expected pc=8", obs_valid, obs_pc); end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] w;
        do_reset();
        lat      = 3;
        bad_data = 1'b1;
        step();
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin errors++; $display("FAIL rw_first: got req=%b addr=%h expected addr 0", obs_req, obs_addr); end
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL rw_redir_req: got %b expected 0", obs_req); end
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin errors++; $display("FAIL rw_drop: got req=%b valid=%b expected 0/0", obs_req, obs_valid); end
        end
        bad_data = 1'b0;
        step();
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin errors++; $display("FAIL rw_refetch: got req=%b addr=%h expected addr 100", obs_req, obs_addr); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped_valid: got %b instr=%h expected 0", obs_valid, obs_instr); end
        end
        step();
        w = word_of(32'h100);
        checks++; if (obs_valid !== 1'b1 || obs_instr !== w || obs_pc !== 32'h100) begin errors++; $display("FAIL rw_new: got v=%b %h pc=%h expected %h pc=100", obs_valid, obs_instr, obs_pc, w); end
    endtask

    task automatic test_redirect_collide();
        logic [31:0] w;
        do_reset();
        instr_ready = 1'b0;
        step();
        step();
        step();
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h4) begin errors++; $display("FAIL rc_setup: got req=%b addr=%h expected addr 4", obs_req, obs_addr); end
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        checks++; if (obs_valid !== 1'b1 || imem_rvalid !== 1'b1 || obs_req !== 1'b0) begin errors++; $display("FAIL rc_collide: got v=%b rvalid=%b req=%b expected 1/1/0", obs_valid, imem_rvalid, obs_req); end
        redirect = 1'b0;
        step();
        checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL rc_flush: got %b expected 0", obs_valid); end
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h200) begin errors++; $display("FAIL rc_run: got req=%b addr=%h expected addr 200", obs_req, obs_addr); end
        step();
        step();
        w = word_of(32'h200);
        checks++; if (obs_valid !== 1'b1 || obs_instr !== w || obs_pc !== 32'h200) begin errors++; $display("FAIL rc_new: got v=%b %h pc=%h expected %h pc=200", obs_valid, obs_instr, obs_pc, w); end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] w;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL wrap_redir_req: got %b expected 0", obs_req); end
        redirect = 1'b0;
        step();
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got req=%b addr=%h expected fffffffc", obs_req, obs_addr); end
        step();
        instr_ready = 1'b0;
        step();
        w = word_of(32'hFFFF_FFFC);
        checks++; if (obs_valid !== 1'b1 || obs_instr !== w || obs_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head: got v=%b %h pc=%h expected %h", obs_valid, obs_instr, obs_pc, w); end
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got req=%b addr=%h expected 0", obs_req, obs_addr); end
        reset       = 1'b1;
        pend        = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", instr_valid); end
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL midreset_pc: got addr=%h req=%b expected 0/0", imem_addr, imem_req); end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        instr_ready = 1'b1;
        step();
        checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin errors++; $display("FAIL midreset_restart: got req=%b addr=%h expected addr 0", obs_req, obs_addr); end
        step();
        step();
        w = word_of(32'h0);
        checks++; if (obs_valid !== 1'b1 || obs_instr !== w || obs_pc !== 32'h0) begin errors++; $display("FAIL midreset_data: got v=%b %h pc=%h expected %h", obs_valid, obs_instr, obs_pc, w); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        step();
        step();
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL perf_stall: got %0d expected 5", stall_cnt); end
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL perf_flush: got %0d expected 1", flush_cnt); end
        step();
        redirect = 1'b0;
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL perf_idle_flush: got %0d expected 1", flush_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_collide();
        test_wrap_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
